// File: rtl/setup_sweep_pkg.sv
// Shared types for the TSPC DFF setup-sweep sequencer: FSM states, result codes
// and the delay-line step size.
package setup_sweep_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        PRE_HI,
        PRE_LO,
        LAUNCH,
        MEAS,
        CHECK,
        RESTORE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        ST_OK_VIOLATION    = 2'd0,
        ST_NO_VIOLATION    = 2'd1,
        ST_FUNC_FAIL_FIRST = 2'd2,
        ST_TIMEOUT         = 2'd3
    } res_status_t;

    // Each delay_idx step adds this much clock lag on the board delay line.
    localparam int DELAY_STEP_PS = 10;

endpackage

// File: rtl/sweep_tick_timer.sv
// Stimulus phase counter: load restarts a TICK_CYCLES-long phase, expire marks
// its last cycle.
module sweep_tick_timer #(
    parameter int TICK_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(TICK_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= RELOAD;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/setup_sweep_seq.sv
// Setup-threshold sweep sequencer: steps the clock delay index down, launches a
// 0->1 data edge per point and finds the smallest index that still passes.
// Optional per-point log stream enabled by defining SETUP_SWEEP_LOG_EN.
module setup_sweep_seq
    import setup_sweep_pkg::*;
#(
    parameter int TICK_CYCLES  = 64,
    parameter int NB_DELAY     = 11,
    parameter int MEAS_W       = 16,
    parameter int PUSHOUT_PCT  = 10,
    parameter int MEAS_TIMEOUT = 1024,
    localparam int IW = (NB_DELAY > 1) ? $clog2(NB_DELAY) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              dut_clk,
    output logic              dut_din,
    output logic [IW-1:0]     delay_idx,
    input  logic              dut_dout,
    input  logic              meas_valid,
    output logic              meas_ready,
    input  logic [MEAS_W-1:0] meas_data,
    output logic              res_valid,
    output logic [IW-1:0]     res_setup_idx,
    output logic [MEAS_W-1:0] res_baseline,
    output logic [1:0]        res_status
`ifdef SETUP_SWEEP_LOG_EN
    ,
    output logic              log_valid,
    output logic [IW-1:0]     log_idx,
    output logic [MEAS_W-1:0] log_meas,
    output logic              log_pass,
    input  logic              log_ready
`endif
);

    localparam logic [IW-1:0] IDX_TOP = IW'(NB_DELAY - 1);
    localparam int PW = MEAS_W + 8;
    localparam int TW = (MEAS_TIMEOUT > 1) ? $clog2(MEAS_TIMEOUT) : 1;
    localparam logic [TW-1:0] WAIT_LAST = TW'(MEAS_TIMEOUT - 1);

    state_t            state;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     last_pass;
    logic [MEAS_W-1:0] baseline;
    logic [MEAS_W-1:0] meas_q;
    logic              pt_fail;
    logic              pt_viol;
    logic [TW-1:0]     wait_cnt;

    logic              timed;
    logic              tick_load;
    logic              tick_expire;
    logic              handshake;
    logic              check_go;
    logic [PW-1:0]     meas_scaled;
    logic [PW-1:0]     limit_scaled;
    logic              viol_now;

    logic              chk_done;
    res_status_t       chk_status;
    logic [IW-1:0]     chk_idx;
    logic [MEAS_W-1:0] chk_base;

    // Untimed states hold the counter loaded, so every timed state starts fresh.
    assign timed     = state inside {SETTLE, PRE_HI, PRE_LO, LAUNCH, RESTORE};
    assign tick_load = !timed || tick_expire;

    sweep_tick_timer #(
        .TICK_CYCLES (TICK_CYCLES)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tick_load),
        .expire (tick_expire)
    );

    assign handshake = meas_valid && meas_ready;

    // Percent pushout test kept in integer form; PW bits hold both products.
    assign meas_scaled  = PW'(meas_data) * PW'(100);
    assign limit_scaled = PW'(baseline) * PW'(100 + PUSHOUT_PCT);
    assign viol_now     = (idx != IDX_TOP) && (meas_scaled > limit_scaled);

`ifdef SETUP_SWEEP_LOG_EN
    assign check_go = !log_valid || log_ready;
`else
    assign check_go = 1'b1;
`endif

    always_comb begin
        chk_done   = 1'b1;
        chk_status = ST_OK_VIOLATION;
        chk_idx    = last_pass;
        chk_base   = baseline;
        if (idx == IDX_TOP && pt_fail) begin
            chk_status = ST_FUNC_FAIL_FIRST;
            chk_idx    = IDX_TOP;
        end else if (!(pt_fail || pt_viol)) begin
            if (idx == '0) begin
                chk_status = ST_NO_VIOLATION;
                chk_idx    = '0;
                chk_base   = (idx == IDX_TOP) ? meas_q : baseline;
            end else begin
                chk_done = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= IDX_TOP;
            last_pass     <= IDX_TOP;
            baseline      <= '0;
            meas_q        <= '0;
            pt_fail       <= 1'b0;
            pt_viol       <= 1'b0;
            wait_cnt      <= '0;
            busy          <= 1'b0;
            dut_clk       <= 1'b0;
            dut_din       <= 1'b0;
            delay_idx     <= IDX_TOP;
            meas_ready    <= 1'b0;
            res_valid     <= 1'b0;
            res_setup_idx <= '0;
            res_baseline  <= '0;
            res_status    <= '0;
`ifdef SETUP_SWEEP_LOG_EN
            log_valid     <= 1'b0;
            log_idx       <= '0;
            log_meas      <= '0;
            log_pass      <= 1'b0;
`endif
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        idx       <= IDX_TOP;
                        delay_idx <= IDX_TOP;
                        last_pass <= IDX_TOP;
                        baseline  <= '0;
                        dut_clk   <= 1'b0;
                        dut_din   <= 1'b0;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (tick_expire) begin
                        dut_clk <= 1'b1;
                        state   <= PRE_HI;
                    end
                end
                PRE_HI: begin
                    if (tick_expire) begin
                        dut_clk <= 1'b0;
                        state   <= PRE_LO;
                    end
                end
                PRE_LO: begin
                    if (tick_expire) begin
                        dut_clk <= 1'b1;
                        dut_din <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    if (tick_expire) begin
                        meas_ready <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= MEAS;
                    end
                end
                MEAS: begin
                    if (handshake) begin
                        meas_ready <= 1'b0;
                        meas_q     <= meas_data;
                        pt_fail    <= !dut_dout;
                        pt_viol    <= viol_now;
                        state      <= CHECK;
`ifdef SETUP_SWEEP_LOG_EN
                        log_valid  <= 1'b1;
                        log_idx    <= idx;
                        log_meas   <= meas_data;
                        log_pass   <= dut_dout && !viol_now;
`endif
                    end else if (wait_cnt == WAIT_LAST) begin
                        meas_ready    <= 1'b0;
                        dut_clk       <= 1'b0;
                        dut_din       <= 1'b0;
                        busy          <= 1'b0;
                        res_valid     <= 1'b1;
                        res_status    <= ST_TIMEOUT;
                        res_setup_idx <= last_pass;
                        res_baseline  <= baseline;
                        state         <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (check_go) begin
`ifdef SETUP_SWEEP_LOG_EN
                        log_valid <= 1'b0;
`endif
                        dut_clk <= 1'b0;
                        dut_din <= 1'b0;
                        if (chk_done) begin
                            busy          <= 1'b0;
                            res_valid     <= 1'b1;
                            res_status    <= chk_status;
                            res_setup_idx <= chk_idx;
                            res_baseline  <= chk_base;
                            state         <= DONE;
                        end else begin
                            last_pass <= idx;
                            if (idx == IDX_TOP) begin
                                baseline <= meas_q;
                            end
                            state <= RESTORE;
                        end
                    end
                end
                RESTORE: begin
                    if (tick_expire) begin
                        idx       <= idx - 1'b1;
                        delay_idx <= idx - 1'b1;
                        state     <= SETTLE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
